// File: rtl/adc_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_spi_pkg
//  Description : Definitions shared by both ends of the ADC serial link:
//                frame width, idle transmit code and the responder FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_spi_pkg;

    // Frame width used by both master and responder.
    localparam int unsigned c_DATA_W    = 8;
    // Word shifted out when no sample is buffered.
    localparam logic [7:0]  c_IDLE_CODE = 8'h00;

    // Responder state encoding.
    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_SHIFT  = 2'd1;
    localparam logic [1:0]  c_ST_HOLD   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_SHIFT = c_ST_SHIFT,
        ST_HOLD  = c_ST_HOLD
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Two-flop synchroniser for one asynchronous pin followed by a
//                third flop for edge detection.
//  Ports       : clk     - sampling clock
//                rst_n   - asynchronous active-low reset
//                i_async - asynchronous pin input
//                o_sync  - synchronised level
//                o_rise  - one-cycle strobe on a synchronised 0->1 edge
//                o_fall  - one-cycle strobe on a synchronised 1->0 edge
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0   // idle level of the pin
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_sync = sync_q;
    assign o_rise = sync_q & ~prev_q;
    assign o_fall = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/adc_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : adc_spi_responder
//  Description : SPI mode-0 responder standing in for the ADC. Serves buffered
//                samples MSB-first on spi_sdo and captures the master's
//                command word from spi_sdi. Pins are oversampled in sys_clk.
//  Ports       : sys_clk, rst_n           - clock, async active-low reset
//                spi_sck/csn/sdi, spi_sdo - serial link
//                sample_data/valid/ready  - sample input handshake
//                cmd_data, cmd_valid      - last command word + update pulse
//                underrun                 - frame started with empty buffer
//                frame_err                - CSN released mid-frame
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int unsigned       DATA_W     = c_DATA_W,
    parameter logic [DATA_W-1:0] IDLE_CODE  = c_IDLE_CODE,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_csn,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic [DATA_W-1:0] cmd_data,
    output logic              cmd_valid,
    output logic              underrun,
    output logic              frame_err
);

    localparam int unsigned c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned c_PTR_W  = c_ADDR_W + 1;
    localparam int unsigned c_CNT_W  = $clog2(DATA_W) + 1;

    // ------------------------------------------------------------------
    // Pin conditioning
    // ------------------------------------------------------------------
    logic w_sck_rise, w_sck_fall, w_sck_s;
    logic w_csn_rise, w_csn_fall, w_csn_s;
    logic w_sdi_s, w_sdi_rise, w_sdi_fall;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
        .clk(sys_clk), .rst_n(rst_n), .i_async(spi_sck),
        .o_sync(w_sck_s), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_csn (
        .clk(sys_clk), .rst_n(rst_n), .i_async(spi_csn),
        .o_sync(w_csn_s), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
    );
    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sdi (
        .clk(sys_clk), .rst_n(rst_n), .i_async(spi_sdi),
        .o_sync(w_sdi_s), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall)
    );

    // The synchronisers come out of reset at the idle levels, so releasing
    // reset with CSN already low would look like a CSN fall. Frames are only
    // accepted once the synchronised CSN has been seen high after the
    // synchroniser pipeline has flushed.
    logic [1:0] settle_q, settle_d;
    logic       armed_q, armed_d;

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  mem_d [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic               w_empty, w_full, w_push, w_pop;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_ADDR_W] != rd_ptr_q[c_ADDR_W]) &&
                     (wr_ptr_q[c_ADDR_W-1:0] == rd_ptr_q[c_ADDR_W-1:0]);
    assign w_push  = sample_valid && !w_full;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            mem_d[wr_ptr_q[c_ADDR_W-1:0]] = sample_data;
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    spi_state_e         state_q, state_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               sdo_q, sdo_d;
    logic [DATA_W-1:0]  cmd_data_q, cmd_data_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               underrun_q, underrun_d;
    logic               frame_err_q, frame_err_d;

    always_comb begin
        settle_d    = {settle_q[0], 1'b1};
        armed_d     = armed_q | (settle_q[1] & w_csn_s);
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        sdo_d       = sdo_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        w_pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sdo_d = 1'b0;
                if (w_csn_fall && armed_q) begin
                    // Emptiness is judged before this cycle's push, so a
                    // sample arriving together with the frame start waits.
                    if (!w_empty) begin
                        tx_d  = mem_q[rd_ptr_q[c_ADDR_W-1:0]];
                        w_pop = 1'b1;
                    end else begin
                        tx_d       = IDLE_CODE;
                        underrun_d = 1'b1;
                    end
                    sdo_d   = tx_d[DATA_W-1];
                    cnt_d   = '0;
                    rx_d    = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (w_csn_rise) begin
                    frame_err_d = 1'b1;
                    rx_d        = '0;
                    sdo_d       = 1'b0;
                    state_d     = ST_IDLE;
                end else if (w_sck_rise) begin
                    rx_d  = {rx_q[DATA_W-2:0], w_sdi_s};
                    cnt_d = cnt_q + c_CNT_W'(1);
                    if (cnt_q == c_CNT_W'(DATA_W - 1)) begin
                        cmd_data_d  = rx_d;
                        cmd_valid_d = 1'b1;
                        sdo_d       = 1'b0;
                        state_d     = ST_HOLD;
                    end
                end else if (w_sck_fall) begin
                    tx_d  = {tx_q[DATA_W-2:0], 1'b0};
                    sdo_d = tx_q[DATA_W-2];
                end
            end

            ST_HOLD: begin
                sdo_d = 1'b0;
                if (w_csn_rise) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                sdo_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q    <= '0;
            armed_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            state_q     <= ST_IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            sdo_q       <= 1'b0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            sdo_q       <= sdo_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi_sdo      = sdo_q;
    assign sample_ready = !w_full;
    assign cmd_data     = cmd_data_q;
    assign cmd_valid    = cmd_valid_q;
    assign underrun     = underrun_q;
    assign frame_err    = frame_err_q;

    // Level outputs of SCK and the SDI edge strobes are not needed here.
    logic w_unused;
    assign w_unused = w_sck_s ^ w_sdi_rise ^ w_sdi_fall;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_spi_responder
//  Description : Directed self-checking bench for adc_spi_responder. Acts as
//                the SPI master with SCK at one tenth of sys_clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_spi_responder;

    localparam int c_HALF = 5;   // sys_clk cycles per SCK half period

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_sdi = 1'b0;
    logic       spi_sdo;
    logic [7:0] sample_data  = 8'h00;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       underrun;
    logic       frame_err;

    adc_spi_responder dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .spi_sck     (spi_sck),
        .spi_csn     (spi_csn),
        .spi_sdi     (spi_sdi),
        .spi_sdo     (spi_sdo),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .underrun    (underrun),
        .frame_err   (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Number of cycles each pulse output was seen high.
    int n_cmd  = 0;
    int n_und  = 0;
    int n_ferr = 0;
    always @(negedge sys_clk) begin
        if (cmd_valid) n_cmd  <= n_cmd + 1;
        if (underrun)  n_und  <= n_und + 1;
        if (frame_err) n_ferr <= n_ferr + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic push(input logic [7:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        cyc(1);
        sample_valid = 1'b0;
    endtask

    // Clocks n bits out of mosi (MSB of the n-bit field first) and returns the
    // bits read from spi_sdo, sampled just before each SCK rise.
    task automatic xfer(input logic [15:0] mosi, input int n, output logic [15:0] miso);
        miso = '0;
        for (int i = 0; i < n; i++) begin
            spi_sdi = mosi[n-1-i];
            cyc(c_HALF);
            miso    = {miso[14:0], spi_sdo};
            spi_sck = 1'b1;
            cyc(c_HALF);
            spi_sck = 1'b0;
        end
        spi_sdi = 1'b0;
    endtask

    task automatic frame(input logic [15:0] mosi, input int n, output logic [15:0] miso);
        spi_csn = 1'b0;
        xfer(mosi, n, miso);
        cyc(c_HALF);
        spi_csn = 1'b1;
        cyc(8);
    endtask

    initial begin
        logic [15:0] rd;
        int s_cmd, s_und, s_ferr;

        // ---------------- reset values ----------------
        cyc(3);
        chk("rst_sdo",   {15'd0, spi_sdo},      16'h0000);
        chk("rst_ready", {15'd0, sample_ready}, 16'h0001);
        chk("rst_cmd",   {8'd0, cmd_data},      16'h0000);
        chk("rst_pulses", {13'd0, cmd_valid, underrun, frame_err}, 16'h0000);
        rst_n = 1'b1;
        cyc(6);

        // ---------------- single frame ----------------
        s_cmd = n_cmd; s_und = n_und; s_ferr = n_ferr;
        push(8'hA5);
        frame({8'h00, 8'h3C}, 8, rd);
        chk("t1_miso", rd, 16'h00A5);
        chk("t1_cmd", {8'd0, cmd_data}, 16'h003C);
        chk("t1_cmd_valid_cnt", 16'(n_cmd - s_cmd), 16'd1);
        chk("t1_underrun_cnt", 16'(n_und - s_und), 16'd0);
        chk("t1_frame_err_cnt", 16'(n_ferr - s_ferr), 16'd0);

        // ---------------- FIFO full ----------------
        push(8'h01);
        chk("t2_ready_one", {15'd0, sample_ready}, 16'h0001);
        push(8'h02);
        chk("t2_ready_full", {15'd0, sample_ready}, 16'h0000);
        sample_data  = 8'h03;
        sample_valid = 1'b1;
        cyc(2);
        sample_valid = 1'b0;
        chk("t2_ready_still_full", {15'd0, sample_ready}, 16'h0000);
        spi_csn = 1'b0;
        cyc(4);
        chk("t2_ready_after_start", {15'd0, sample_ready}, 16'h0001);
        xfer({8'h00, 8'h11}, 8, rd);
        cyc(c_HALF);
        spi_csn = 1'b1;
        cyc(8);
        chk("t2_miso_first", rd, 16'h0001);
        frame({8'h00, 8'h22}, 8, rd);
        chk("t2_miso_second", rd, 16'h0002);
        chk("t2_cmd", {8'd0, cmd_data}, 16'h0022);

        // ---------------- empty FIFO: underrun (0x03 was refused) ----------------
        s_und = n_und; s_cmd = n_cmd;
        frame({8'h00, 8'h5A}, 8, rd);
        chk("t3_miso_idle", rd, 16'h0000);
        chk("t3_underrun_cnt", 16'(n_und - s_und), 16'd1);
        chk("t3_cmd", {8'd0, cmd_data}, 16'h005A);
        chk("t3_cmd_valid_cnt", 16'(n_cmd - s_cmd), 16'd1);

        // ---------------- aborted frame ----------------
        push(8'h77);
        push(8'h88);
        s_cmd = n_cmd; s_ferr = n_ferr;
        frame(16'h0015, 5, rd);
        chk("t4_miso_partial", rd, 16'h000E);
        chk("t4_frame_err_cnt", 16'(n_ferr - s_ferr), 16'd1);
        chk("t4_no_cmd_valid", 16'(n_cmd - s_cmd), 16'd0);
        chk("t4_cmd_kept", {8'd0, cmd_data}, 16'h005A);
        frame({8'h00, 8'hC3}, 8, rd);
        chk("t4_next_miso", rd, 16'h0088);
        chk("t4_next_cmd", {8'd0, cmd_data}, 16'h00C3);

        // ---------------- over-long frame ----------------
        push(8'hFF);
        s_cmd = n_cmd; s_ferr = n_ferr;
        frame({6'd0, 8'h96, 2'b11}, 10, rd);
        chk("t5_miso_10bit", rd, 16'h03FC);
        chk("t5_cmd", {8'd0, cmd_data}, 16'h0096);
        chk("t5_cmd_valid_cnt", 16'(n_cmd - s_cmd), 16'd1);
        chk("t5_frame_err_cnt", 16'(n_ferr - s_ferr), 16'd0);

        // ---------------- reset mid-frame ----------------
        push(8'h5C);
        s_cmd = n_cmd;
        spi_csn = 1'b0;
        xfer(16'h0005, 3, rd);
        rst_n = 1'b0;
        cyc(2);
        chk("t6_rst_sdo",   {15'd0, spi_sdo},      16'h0000);
        chk("t6_rst_ready", {15'd0, sample_ready}, 16'h0001);
        chk("t6_rst_cmd",   {8'd0, cmd_data},      16'h0000);
        rst_n = 1'b1;
        cyc(4);
        s_und = n_und;
        xfer({8'h00, 8'hE7}, 8, rd);
        cyc(c_HALF);
        chk("t6_no_frame_miso", rd, 16'h0000);
        chk("t6_no_frame_underrun", 16'(n_und - s_und), 16'd0);
        chk("t6_no_cmd_valid", 16'(n_cmd - s_cmd), 16'd0);
        chk("t6_cmd_still_reset", {8'd0, cmd_data}, 16'h0000);
        spi_csn = 1'b1;
        cyc(8);
        push(8'h3E);
        frame({8'h00, 8'h81}, 8, rd);
        chk("t6_after_miso", rd, 16'h003E);
        chk("t6_after_cmd", {8'd0, cmd_data}, 16'h0081);
        chk("t6_after_cmd_valid_cnt", 16'(n_cmd - s_cmd), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
